shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 138 +++++++++++++
 tb/tb_shift_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA sequencer for the execute stage, with valid/ready handshakes in and out.
// Optional macro SHIFT_SEQ_NIBBLE_EN: 4-bit steps while the remaining count is at least 4.
module shift_sequencer #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [SW-1:0]   shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   work_q, work_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   step1;

    // One-position shift of the work register; SRA replicates the current MSB.
    always_comb begin
        case (op_q)
            OP_SRL:  step1 = {1'b0, work_q[XLEN-1:1]};
            OP_SRA:  step1 = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: step1 = {work_q[XLEN-2:0], 1'b0};
        endcase
    end

`ifdef SHIFT_SEQ_NIBBLE_EN
    logic [XLEN-1:0] step4;

    always_comb begin
        case (op_q)
            OP_SRL:  step4 = {4'b0000, work_q[XLEN-1:4]};
            OP_SRA:  step4 = {{4{work_q[XLEN-1]}}, work_q[XLEN-1:4]};
            default: step4 = {work_q[XLEN-5:0], 4'b0000};
        endcase
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d    = op;
                    work_d  = a;
                    cnt_d   = shamt;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
`ifdef SHIFT_SEQ_NIBBLE_EN
                if (cnt_q >= SW'(4)) begin
                    work_d = step4;
                    cnt_d  = cnt_q - SW'(4);
                end else begin
                    work_d = step1;
                    cnt_d  = cnt_q - SW'(1);
                end
`else
                work_d = step1;
                cnt_d  = cnt_q - SW'(1);
`endif
                if (cnt_d == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = work_d;
                end
            end
            DONE: begin
                // A zero-amount request arrives here without a result yet; publish it one cycle later.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    result_d    = work_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            work_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and random self-checking bench for shift_sequencer (XLEN = 32).
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int errors = 0;
    int checks = 0;

    shift_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input int s);
        int l;
`ifdef SHIFT_SEQ_NIBBLE_EN
        l = s / 4 + s % 4;
`else
        l = s;
`endif
        return (l < 1) ? 1 : l;
    endfunction

    // Issue one request and count edges from acceptance until out_valid.
    task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [4:0] s,
                         output int lat, output logic [31:0] res, output int busy_low);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = av; shamt = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        busy_low = 0;
        while (!out_valid && lat < 100) begin
            if (busy !== 1'b1) busy_low++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b1) busy_low++;
        res = result;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; a = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: got v=%b b=%b r=%h expected 0 0 0", out_valid, busy, result);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_sll();
        int lat, bl;
        logic [31:0] r;
        do_op(2'b00, 32'h0000_0001, 5'd31, lat, r, bl);
        checks++;
        if (r !== 32'h8000_0000) begin errors++; $display("FAIL sll31_result: got %h expected 80000000", r); end
        checks++;
        if (lat !== exp_lat(31)) begin errors++; $display("FAIL sll31_latency: got %0d expected %0d", lat, exp_lat(31)); end
        checks++;
        if (bl !== 0) begin errors++; $display("FAIL sll31_busy: got %0d low cycles expected 0", bl); end
        consume();
        do_op(2'b11, 32'h0000_00FF, 5'd8, lat, r, bl);
        checks++;
        if (r !== 32'h0000_FF00) begin errors++; $display("FAIL reserved_op_result: got %h expected 0000ff00", r); end
        checks++;
        if (lat !== exp_lat(8)) begin errors++; $display("FAIL reserved_op_latency: got %0d expected %0d", lat, exp_lat(8)); end
        consume();
    endtask

    task automatic test_sra_srl();
        int lat, bl;
        logic [31:0] r;
        do_op(2'b10, 32'h8000_00F0, 5'd4, lat, r, bl);
        checks++;
        if (r !== 32'hF800_000F) begin errors++; $display("FAIL sra4_result: got %h expected f800000f", r); end
        checks++;
        if (lat !== exp_lat(4)) begin errors++; $display("FAIL sra4_latency: got %0d expected %0d", lat, exp_lat(4)); end
        consume();
        do_op(2'b01, 32'h8000_00F0, 5'd4, lat, r, bl);
        checks++;
        if (r !== 32'h0800_000F) begin errors++; $display("FAIL srl4_result: got %h expected 0800000f", r); end
        checks++;
        if (lat !== exp_lat(4)) begin errors++; $display("FAIL srl4_latency: got %0d expected %0d", lat, exp_lat(4)); end
        consume();
    endtask

    task automatic test_zero_shift();
        int lat, bl;
        logic [31:0] r;
        do_op(2'b10, 32'hDEAD_BEEF, 5'd0, lat, r, bl);
        checks++;
        if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_result: got %h expected deadbeef", r); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
        consume();
    endtask

    task automatic test_hold();
        int lat, bl, bad;
        logic [31:0] r;
        do_op(2'b01, 32'h0000_00F0, 5'd4, lat, r, bl);
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== 32'h0000_000F || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release: got rdy=%b v=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 32'h0000_0001; shamt = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_shift: got rdy=%b busy=%b v=%b expected 1 0 0", in_ready, busy, out_valid);
        end
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen); end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; shamt = 5'd3;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_idle_accept: got rdy=%b busy=%b expected 1 0", in_ready, busy);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_rst_done();
        int lat, bl;
        logic [31:0] r;
        do_op(2'b00, 32'h0000_0003, 5'd3, lat, r, bl);
        checks++;
        if (r !== 32'h0000_0018 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pre_result: got %h v=%b expected 00000018 1", r, out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_done: got v=%b r=%h busy=%b rdy=%b expected 0 0 0 0",
                               out_valid, result, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release: got %b expected 1", in_ready); end
    endtask

    task automatic test_random();
        int lat, bl, bad_r, bad_l;
        logic [31:0] r, av, ref_v;
        logic [1:0]  o;
        logic [4:0]  s;
        bad_r = 0;
        bad_l = 0;
        for (int i = 0; i < 400; i++) begin
            o  = 2'($urandom_range(0, 3));
            av = $urandom;
            s  = 5'($urandom_range(0, 31));
            case (o)
                2'b01:   ref_v = av >> s;
                2'b10:   ref_v = 32'($signed(av) >>> s);
                default: ref_v = av << s;
            endcase
            do_op(o, av, s, lat, r, bl);
            checks++;
            if (r !== ref_v) begin
                errors++; bad_r++;
                if (bad_r < 5) $display("FAIL random_result: op=%0d a=%h s=%0d got %h expected %h", o, av, s, r, ref_v);
            end
            checks++;
            if (lat !== exp_lat(int'(s))) begin
                errors++; bad_l++;
                if (bad_l < 5) $display("FAIL random_latency: s=%0d got %0d expected %0d", s, lat, exp_lat(int'(s)));
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_zero_shift();
        test_hold();
        test_flush();
        test_rst_done();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
